// File: rtl/fpu_ss_pkg.sv
// Shared types and helpers for the FPU subsystem core arbiter.
// Provides the core-id width function, the default core-id width and the lock FSM states.
package fpu_ss_pkg;

  function automatic int core_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NB_CORES = 8;
  localparam int CORE_ID_W    = core_id_w(DEF_NB_CORES);
  localparam int CNT_W        = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/fpu_ss_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
// Ports: req (N), ptr (start index) -> gnt (onehot), gnt_idx (index of winner).
module fpu_ss_rr_arbiter
  import fpu_ss_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = core_id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   j;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_ss_core_arbiter.sv
// Shares one FPU subsystem issue port among NB_CORES cores with per-core credits.
// Ports: per-core issue/result handshakes, single subsystem issue/result path,
// per-core outstanding counts and a one-cycle result error pulse.
module fpu_ss_core_arbiter
  import fpu_ss_pkg::*;
#(
  parameter  int NB_CORES        = 8,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int ID_WIDTH        = 4,
  localparam int CIW             = core_id_w(NB_CORES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_CORES-1:0]          core_issue_valid_i,
  input  logic [NB_CORES*ID_WIDTH-1:0] core_issue_id_i,
  output logic [NB_CORES-1:0]          core_issue_ready_o,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [ID_WIDTH-1:0]          issue_id_o,
  output logic [CIW-1:0]               issue_core_id_o,
  input  logic                         result_valid_i,
  input  logic [CIW-1:0]               result_core_id_i,
  output logic                         result_ready_o,
  output logic [NB_CORES-1:0]          core_result_valid_o,
  input  logic [NB_CORES-1:0]          core_result_ready_i,
  output logic [NB_CORES*4-1:0]        outstanding_o,
  output logic                         result_err_o
);

  arb_state_t          state;
  logic [CIW-1:0]      ptr;
  logic [CIW-1:0]      lock_idx;
  logic [CIW-1:0]      arb_idx;
  logic [CIW-1:0]      gnt_idx;
  logic [CNT_W-1:0]    cnt [NB_CORES];
  logic [NB_CORES-1:0] eligible;
  logic [NB_CORES-1:0] arb_gnt;
  logic [NB_CORES-1:0] gnt_oh;
  logic [NB_CORES-1:0] inc;
  logic [NB_CORES-1:0] dec;
  logic                lock_hold;
  logic                issue_hs;
  logic                res_in_range;
  logic                res_ready;
  logic                res_cnt_zero;
  logic                res_hs;

  always_comb begin
    for (int c = 0; c < NB_CORES; c++) begin
      eligible[c] = core_issue_valid_i[c]
                  & (cnt[c] < CNT_W'(MAX_OUTSTANDING));
      outstanding_o[c*4 +: 4] = cnt[c];
    end
  end

  fpu_ss_rr_arbiter #(
    .N(NB_CORES)
  ) u_rr (
    .req    (eligible),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx)
  );

  // A held grant survives only while its core keeps requesting;
  // a dropped request falls back to fresh arbitration this cycle.
  assign lock_hold = (state == ARB_LOCKED)
                   & core_issue_valid_i[lock_idx];
  assign gnt_idx   = lock_hold ? lock_idx : arb_idx;
  assign gnt_oh    = lock_hold ? (NB_CORES'(1) << lock_idx)
                               : arb_gnt;

  assign issue_valid_o      = ~rst_i & (lock_hold | (|eligible));
  assign issue_hs           = issue_valid_o & issue_ready_i;
  assign core_issue_ready_o = issue_hs ? gnt_oh : '0;
  assign issue_id_o         = core_issue_id_i[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH];
  assign issue_core_id_o    = gnt_idx;

  // Out-of-range owner ids are accepted and dropped.
  always_comb begin
    res_in_range        = 1'b0;
    res_ready           = 1'b1;
    res_cnt_zero        = 1'b0;
    core_result_valid_o = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      if (result_core_id_i == CIW'(k)) begin
        res_in_range           = 1'b1;
        res_ready              = core_result_ready_i[k];
        res_cnt_zero           = (cnt[k] == '0);
        core_result_valid_o[k] = result_valid_i & ~rst_i;
      end
    end
  end

  assign result_ready_o = res_ready & ~rst_i;
  assign res_hs         = result_valid_i & result_ready_o;

  always_comb begin
    for (int c = 0; c < NB_CORES; c++) begin
      inc[c] = issue_hs & gnt_oh[c];
      dec[c] = res_hs & (result_core_id_i == CIW'(c))
             & (cnt[c] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ARB_IDLE;
      ptr          <= '0;
      lock_idx     <= '0;
      result_err_o <= 1'b0;
      for (int c = 0; c < NB_CORES; c++) cnt[c] <= '0;
    end else begin
      result_err_o <= res_hs & (~res_in_range | res_cnt_zero);
      if (issue_hs) begin
        state <= ARB_IDLE;
        ptr   <= (gnt_idx == CIW'(NB_CORES-1)) ? '0 : gnt_idx + 1'b1;
      end else if (issue_valid_o) begin
        state    <= ARB_LOCKED;
        lock_idx <= gnt_idx;
      end else begin
        state <= ARB_IDLE;
      end
      for (int c = 0; c < NB_CORES; c++) begin
        if (inc[c] & ~dec[c])      cnt[c] <= cnt[c] + 1'b1;
        else if (dec[c] & ~inc[c]) cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

endmodule
